// File: rtl/mem_controller.sv
// Fixed-latency memory controller: independent write and read ports in front of a
// word-addressed array, each acknowledged after its own pipeline latency.
module mem_controller #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 65536,
    parameter int RD_LATENCY = 4,
    parameter int WR_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] wr_address,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [ADDR_WIDTH-1:0] wr_ret_address,
    output logic                  wr_ret_ack,
    input  logic [ADDR_WIDTH-1:0] rd_address,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_ret_data,
    output logic [ADDR_WIDTH-1:0] rd_ret_address,
    output logic                  rd_ret_ack
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // DEPTH is a power of two, so the low address bits form the word index.
    logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};

    logic [IDX_W-1:0]      wr_idx;
    logic [IDX_W-1:0]      rd_idx;
    logic                  wr_acc;
    logic                  rd_acc;
    logic [DATA_WIDTH-1:0] rd_word;

    assign wr_idx = wr_address[IDX_W-1:0];
    assign rd_idx = rd_address[IDX_W-1:0];
    assign wr_acc = wr_en && !reset;
    assign rd_acc = rd_en && !reset;

    // Write-first: a same-edge write to the read index forwards its data.
    always_comb begin
        rd_word = mem[rd_idx];
        if (wr_en && (wr_idx == rd_idx))
            rd_word = wr_data;
    end

    always_ff @(posedge clk) begin
        if (wr_acc)
            mem[wr_idx] <= wr_data;
    end

    logic [RD_LATENCY:1]   rd_vld_pipe;
    logic [ADDR_WIDTH-1:0] rd_addr_pipe [1:RD_LATENCY];
    logic [DATA_WIDTH-1:0] rd_data_pipe [1:RD_LATENCY];
    logic [WR_LATENCY:1]   wr_vld_pipe;
    logic [ADDR_WIDTH-1:0] wr_addr_pipe [1:WR_LATENCY];

    // Idle stages carry zeros so the last stage can drive the outputs directly.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_vld_pipe <= '0;
            for (int i = 1; i <= RD_LATENCY; i++) begin
                rd_addr_pipe[i] <= '0;
                rd_data_pipe[i] <= '0;
            end
        end else begin
            rd_vld_pipe[1]  <= rd_en;
            rd_addr_pipe[1] <= rd_en ? rd_address : '0;
            rd_data_pipe[1] <= rd_en ? rd_word : '0;
            for (int i = 2; i <= RD_LATENCY; i++) begin
                rd_vld_pipe[i]  <= rd_vld_pipe[i-1];
                rd_addr_pipe[i] <= rd_addr_pipe[i-1];
                rd_data_pipe[i] <= rd_data_pipe[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_vld_pipe <= '0;
            for (int i = 1; i <= WR_LATENCY; i++)
                wr_addr_pipe[i] <= '0;
        end else begin
            wr_vld_pipe[1]  <= wr_en;
            wr_addr_pipe[1] <= wr_en ? wr_address : '0;
            for (int i = 2; i <= WR_LATENCY; i++) begin
                wr_vld_pipe[i]  <= wr_vld_pipe[i-1];
                wr_addr_pipe[i] <= wr_addr_pipe[i-1];
            end
        end
    end

    assign rd_ret_ack     = rd_vld_pipe[RD_LATENCY];
    assign rd_ret_address = rd_addr_pipe[RD_LATENCY];
    assign rd_ret_data    = rd_data_pipe[RD_LATENCY];
    assign wr_ret_ack     = wr_vld_pipe[WR_LATENCY];
    assign wr_ret_address = wr_addr_pipe[WR_LATENCY];

endmodule

// File: tb/tb_mem_controller.sv
// Scoreboard bench for mem_controller: a reference memory predicts each ack,
// and a negedge monitor pops and compares acks as the DUT emits them.
module tb_mem_controller;

    localparam int AW    = 16;
    localparam int DW    = 16;
    localparam int DEPTH = 256;
    localparam int RL    = 4;
    localparam int WL    = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] wr_address = '0;
    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic [AW-1:0] wr_ret_address;
    logic          wr_ret_ack;
    logic [AW-1:0] rd_address = '0;
    logic          rd_en = 1'b0;
    logic [DW-1:0] rd_ret_data;
    logic [AW-1:0] rd_ret_address;
    logic          rd_ret_ack;

    always #5 clk = ~clk;

    mem_controller #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH),
        .RD_LATENCY(RL), .WR_LATENCY(WL)
    ) dut (
        .clk(clk), .reset(reset),
        .wr_address(wr_address), .wr_en(wr_en), .wr_data(wr_data),
        .wr_ret_address(wr_ret_address), .wr_ret_ack(wr_ret_ack),
        .rd_address(rd_address), .rd_en(rd_en),
        .rd_ret_data(rd_ret_data), .rd_ret_address(rd_ret_address), .rd_ret_ack(rd_ret_ack)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    exp_t          rd_q[$];
    exp_t          wr_q[$];
    logic [DW-1:0] model [DEPTH];
    int            cyc = 0;
    int            checks = 0;
    int            passed = 0;
    int            rd_seen = 0;
    int            wr_seen = 0;
    bit            mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Called just after a rising edge; the request is accepted at the next edge.
    task automatic drive(input bit we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input bit re, input logic [AW-1:0] ra);
        exp_t e;
        wr_en = we; wr_address = wa; wr_data = wd;
        rd_en = re; rd_address = ra;
        if (!reset) begin
            if (we) begin
                model[int'(wa) % DEPTH] = wd;
                e = '{wa, '0, cyc + WL};
                wr_q.push_back(e);
            end
            if (re) begin
                e = '{ra, model[int'(ra) % DEPTH], cyc + RL};
                rd_q.push_back(e);
            end
        end
        @(posedge clk); #1;
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    task automatic apply_reset(input int n);
        reset = 1'b1;
        repeat (n) begin
            @(posedge clk); #1;
            rd_q.delete();
            wr_q.delete();
        end
        reset = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((rd_q.size() != 0 || wr_q.size() != 0) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (rd_q.size() != 0 || wr_q.size() != 0)
            $display("FAIL %s_drain: pending rd=%0d wr=%0d, required 0", name, rd_q.size(), wr_q.size());
        else
            passed++;
    endtask

    task automatic monitor();
        exp_t e;
        bit   rd_exp;
        bit   wr_exp;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                rd_exp = (rd_q.size() != 0) && (rd_q[0].due == cyc);
                if (rd_ret_ack === 1'b1) rd_seen++;
                checks++;
                if (rd_ret_ack !== rd_exp) begin
                    $display("FAIL rd_ack cyc=%0d: got %b, required %b", cyc, rd_ret_ack, rd_exp);
                    if (rd_exp) void'(rd_q.pop_front());
                end else if (rd_exp) begin
                    e = rd_q.pop_front();
                    if (rd_ret_address !== e.addr || rd_ret_data !== e.data)
                        $display("FAIL rd_ret cyc=%0d: got addr %h data %h, required addr %h data %h",
                                 cyc, rd_ret_address, rd_ret_data, e.addr, e.data);
                    else
                        passed++;
                end else if (rd_ret_address !== '0 || rd_ret_data !== '0) begin
                    $display("FAIL rd_idle cyc=%0d: got addr %h data %h, required 0", cyc, rd_ret_address, rd_ret_data);
                end else begin
                    passed++;
                end

                wr_exp = (wr_q.size() != 0) && (wr_q[0].due == cyc);
                if (wr_ret_ack === 1'b1) wr_seen++;
                checks++;
                if (wr_ret_ack !== wr_exp) begin
                    $display("FAIL wr_ack cyc=%0d: got %b, required %b", cyc, wr_ret_ack, wr_exp);
                    if (wr_exp) void'(wr_q.pop_front());
                end else if (wr_exp) begin
                    e = wr_q.pop_front();
                    if (wr_ret_address !== e.addr)
                        $display("FAIL wr_ret cyc=%0d: got addr %h, required %h", cyc, wr_ret_address, e.addr);
                    else
                        passed++;
                end else if (wr_ret_address !== '0) begin
                    $display("FAIL wr_idle cyc=%0d: got addr %h, required 0", cyc, wr_ret_address);
                end else begin
                    passed++;
                end
            end
        end
    endtask

    task automatic test_reset();
        wr_en = 1'b1; rd_en = 1'b1;
        wr_address = 16'h0042; wr_data = 16'hFFFF; rd_address = 16'h0042;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (wr_ret_ack !== 1'b0 || rd_ret_ack !== 1'b0 || wr_ret_address !== '0 ||
                rd_ret_address !== '0 || rd_ret_data !== '0)
                $display("FAIL reset_outputs: got wa=%b ra=%b waddr=%h raddr=%h rdata=%h, required all 0",
                         wr_ret_ack, rd_ret_ack, wr_ret_address, rd_ret_address, rd_ret_data);
            else
                passed++;
        end
        reset = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        mon_en = 1'b1;
        repeat (RL + 2) @(posedge clk);
        #1;
        checks++;
        if (rd_seen !== 0 || wr_seen !== 0)
            $display("FAIL reset_no_ack: got rd=%0d wr=%0d acks, required 0", rd_seen, wr_seen);
        else
            passed++;
    endtask

    task automatic test_write_read();
        int r0 = rd_seen;
        int w0 = wr_seen;
        drive(1'b1, 16'h0096, 16'h1234, 1'b0, '0);
        drive(1'b0, '0, '0, 1'b1, 16'h0096);
        drain("write_read");
        checks++;
        if (rd_seen - r0 !== 1 || wr_seen - w0 !== 1)
            $display("FAIL write_read_count: got rd=%0d wr=%0d, required 1/1", rd_seen - r0, wr_seen - w0);
        else
            passed++;
    endtask

    task automatic test_back_to_back();
        int r0 = rd_seen;
        int w0 = wr_seen;
        for (int k = 0; k < 500; k++)
            drive(1'b1, AW'(150 + k), DW'(k), 1'b1, AW'(k));
        drain("stream");
        checks++;
        if (rd_seen - r0 !== 500 || wr_seen - w0 !== 500)
            $display("FAIL stream_count: got rd=%0d wr=%0d, required 500/500", rd_seen - r0, wr_seen - w0);
        else
            passed++;
    endtask

    task automatic test_collision();
        drive(1'b1, 16'h0010, 16'h0001, 1'b0, '0);
        drive(1'b1, 16'h0010, 16'hBEEF, 1'b1, 16'h0010);
        drive(1'b0, '0, '0, 1'b1, 16'h0010);
        drain("collision");
    endtask

    task automatic test_reset_midflight();
        int r0;
        drive(1'b1, 16'h0033, 16'h5A5A, 1'b0, '0);
        drain("midflight_setup");
        r0 = rd_seen;
        drive(1'b0, '0, '0, 1'b1, 16'h0033);
        drive(1'b0, '0, '0, 1'b1, 16'h0034);
        drive(1'b0, '0, '0, 1'b1, 16'h0035);
        apply_reset(2);
        repeat (RL + 2) @(posedge clk);
        #1;
        checks++;
        if (rd_seen !== r0)
            $display("FAIL midflight_discard: got %0d rd acks, required 0", rd_seen - r0);
        else
            passed++;
        drive(1'b0, '0, '0, 1'b1, 16'h0033);
        drain("midflight_reread");
    endtask

    task automatic test_wrap();
        drive(1'b1, 16'h0105, 16'h00AA, 1'b0, '0);
        drive(1'b0, '0, '0, 1'b1, 16'h0005);
        drain("wrap");
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        fork
            monitor();
        join_none
        test_reset();
        test_write_read();
        test_back_to_back();
        test_collision();
        test_reset_midflight();
        test_wrap();
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
